// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage - instruction-fetch stage
//
// Owns the PC, issues single-word fetches to the memory controller over a
// level req / pulse ack handshake, and presents {if_pc, if_inst} to the
// IF/ID register from a one-entry output buffer. if_inst == 0 is a bubble.
//
// Ports
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-low reset
//   ifid_stall           in   IF/ID holds the presented instruction
//   branch_interception  in   redirect request (beats stall and ack)
//   branch_target        in   redirect PC
//   mem_req              out  fetch request, held until mem_ack
//   mem_addr             out  fetch address, stable while mem_req = 1
//   mem_ack              in   one-cycle completion pulse
//   mem_rdata            in   fetched word, valid with mem_ack
//   if_pc                out  PC of presented instruction (0 on bubble)
//   if_inst              out  presented instruction (0 = bubble)
//   perf_fetched         out  accepted fetches, saturating  (IF_PERF_CNT_EN)
//   perf_dropped         out  discarded fetches, saturating (IF_PERF_CNT_EN)
//
// Build option: define IF_PERF_CNT_EN to add the two performance counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | request outstanding (or about to be raised) at pc
// HOLD  | buffer full, no request, waiting for IF/ID to consume
// DROP  | request to a stale address outstanding, its data is discarded
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            INST_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifid_stall,
  input  logic              branch_interception,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              started_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] stale_q, stale_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic [INST_W-1:0] buf_inst_q, buf_inst_d;
  logic              ack_ok;

  // The request is held low for the reset-release cycle so that the first
  // edge after release is the one that raises it.
  assign mem_req  = started_q && (state_q != ST_HOLD);
  // In DROP the controller is still working on the old address.
  assign mem_addr = (state_q == ST_DROP) ? stale_q : pc_q;
  assign ack_ok   = mem_ack && mem_req;

  assign if_pc    = buf_pc_q;
  assign if_inst  = buf_inst_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stale_d    = stale_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;

    unique case (state_q)
      ST_FETCH: begin
        if (branch_interception) begin
          pc_d       = branch_target;
          buf_pc_d   = '0;
          buf_inst_d = '0;
          // Without an ack the in-flight request must still be waited out.
          if (mem_req && !ack_ok) begin
            state_d = ST_DROP;
            stale_d = pc_q;
          end
        end else if (ack_ok) begin
          buf_pc_d   = pc_q;
          buf_inst_d = mem_rdata;
          pc_d       = pc_q + ADDR_W'(4);
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (branch_interception) begin
          pc_d       = branch_target;
          buf_pc_d   = '0;
          buf_inst_d = '0;
          state_d    = ST_FETCH;
        end else if (!ifid_stall) begin
          buf_pc_d   = '0;
          buf_inst_d = '0;
          state_d    = ST_FETCH;
        end
      end

      ST_DROP: begin
        if (branch_interception) begin
          pc_d       = branch_target;
          buf_pc_d   = '0;
          buf_inst_d = '0;
        end
        if (ack_ok) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      started_q  <= 1'b0;
      pc_q       <= RESET_PC;
      stale_q    <= RESET_PC;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= 1'b1;
      pc_q       <= pc_d;
      stale_q    <= stale_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        ev_fetched;
  logic        ev_dropped;
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;

  assign ev_fetched = (state_q == ST_FETCH) && !branch_interception && ack_ok;
  // A drop is either discarded ack data or a full buffer flushed by redirect.
  assign ev_dropped = ((state_q == ST_FETCH) && branch_interception && ack_ok) ||
                      ((state_q == ST_HOLD)  && branch_interception)           ||
                      ((state_q == ST_DROP)  && ack_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (ev_fetched && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (ev_dropped && (perf_dropped_q != '1)) perf_dropped_q <= perf_dropped_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule
